// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for the word-addressed data memory.
// Loads and word stores complete in the request cycle. Byte and halfword
// stores use a two-cycle read-modify-write and stall the pipeline for the
// first cycle.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned halfword
// and word accesses are trapped (misalign/bad_addr). When undefined, they are
// silently aligned down.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepts requests; loads and word stores finish here
// RMW_WR | writes the merged word of a sub-word store, then back to IDLE

module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        misalign,
  output logic [31:0] bad_addr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] merge_q;
  logic [31:0] eff_addr;
  logic        is_word;
  logic        is_half;
  logic        trap;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Decode access size and the effective (possibly aligned-down) address.
  always_comb begin
    is_word = size[1];
    is_half = (size == 2'b01);
`ifdef MISALIGN_TRAP_EN
    eff_addr = addr;
    trap     = req && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
`else
    eff_addr = addr;
    if (is_word) begin
      eff_addr[1:0] = 2'b00;
    end else if (is_half) begin
      eff_addr[0] = 1'b0;
    end
    trap = 1'b0;
`endif
  end

  // Extract the addressed lane for loads and build the merged word for sub-word stores.
  always_comb begin
    case (eff_addr[1:0])
      2'd0:    lane_b = dm_rdata[7:0];
      2'd1:    lane_b = dm_rdata[15:8];
      2'd2:    lane_b = dm_rdata[23:16];
      default: lane_b = dm_rdata[31:24];
    endcase
    lane_h = eff_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    if (is_word) begin
      load_val = dm_rdata;
    end else if (is_half) begin
      load_val = sign_ext ? {{16{lane_h[15]}}, lane_h} : {16'h0000, lane_h};
    end else begin
      load_val = sign_ext ? {{24{lane_b[7]}}, lane_b} : {24'h000000, lane_b};
    end

    merged = dm_rdata;
    if (is_half) begin
      if (eff_addr[1]) merged[31:16] = wdata[15:0];
      else             merged[15:0]  = wdata[15:0];
    end else begin
      case (eff_addr[1:0])
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end
  end

  // State register plus the read-modify-write capture and trap address.
`ifdef MISALIGN_TRAP_EN
  logic [31:0] bad_addr_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= 32'h0;
      merge_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      bad_addr_q <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MISALIGN_TRAP_EN
          if (trap) bad_addr_q <= addr;
`endif
          if (req && we && !is_word && !trap) begin
            addr_q  <= eff_addr;
            merge_q <= merged;
            state   <= RMW_WR;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign bad_addr = bad_addr_q;
`else
  assign bad_addr = 32'h0;
`endif

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    rdata    = 32'h0;
    ack      = 1'b0;
    busy     = 1'b0;
    misalign = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (trap) begin
            misalign = 1'b1;
            ack      = 1'b1;
          end else if (req && !we) begin
            dm_read = 1'b1;
            dm_addr = eff_addr;
            rdata   = load_val;
            ack     = 1'b1;
          end else if (req && is_word) begin
            dm_write = 1'b1;
            dm_addr  = eff_addr;
            dm_wdata = wdata;
            ack      = 1'b1;
          end else if (req) begin
            dm_read = 1'b1;
            dm_addr = eff_addr;
            busy    = 1'b1;
          end
        end
        RMW_WR: begin
          dm_write = 1'b1;
          dm_addr  = addr_q;
          dm_wdata = merge_q;
          ack      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts
// each cycle's response; a monitor compares at the falling edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        misalign;
  logic [31:0] bad_addr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_read;
  logic        dm_write;
  wire  [31:0] dm_rdata;

  localparam int K_LOAD = 0;
  localparam int K_WST  = 1;
  localparam int K_BUSY = 2;
  localparam int K_RMW  = 3;
  localparam int K_TRAP = 4;

  typedef struct {
    int          kind;
    logic        ack;
    logic        busy;
    logic        mis;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] bad;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem [0:63];
  logic [7:0]  ref_b [0:255];
  logic [31:0] exp_bad = 32'h0;
  int          checks = 0;
  int          errors = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .misalign(misalign), .bad_addr(bad_addr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_read(dm_read), .dm_write(dm_write),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read when strobed, write on the falling edge.
  assign dm_rdata = dm_read ? mem[dm_addr[7:2]] : 32'bz;
  always @(negedge clk) if (dm_write) mem[dm_addr[7:2]] <= dm_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int i;
    i = int'(a[7:0]) & 252;
    return {ref_b[i+3], ref_b[i+2], ref_b[i+1], ref_b[i]};
  endfunction

  function automatic logic [31:0] load_ref(input logic [1:0] sz, input logic sx, input logic [31:0] ea);
    int i;
    logic [7:0]  b;
    logic [15:0] h;
    i = int'(ea[7:0]);
    if (sz[1]) return ref_word(ea);
    if (sz == 2'b00) begin
      b = ref_b[i];
      return sx ? {{24{b[7]}}, b} : {24'h0, b};
    end
    h = {ref_b[i+1], ref_b[i]};
    return sx ? {{16{h[15]}}, h} : {16'h0, h};
  endfunction

  task automatic set_word(input int a, input logic [31:0] v);
    mem[a/4] = v;
    for (int k = 0; k < 4; k++) ref_b[(a & 252) + k] = v[8*k +: 8];
  endtask

  task automatic idle_cycle();
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] ea;
    logic        m;
    int          i;
    ea = a;
`ifdef MISALIGN_TRAP_EN
    m = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    m = 1'b0;
    if (sz[1]) ea[1:0] = 2'b00;
    else if (sz == 2'b01) ea[0] = 1'b0;
`endif
    i = int'(ea[7:0]);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    e = '{kind: K_LOAD, ack: 1'b0, busy: 1'b0, mis: 1'b0, rd: 1'b0, wr: 1'b0,
          rdata: 32'h0, daddr: 32'h0, dwdata: 32'h0, bad: exp_bad};
    if (m) begin
      e.kind = K_TRAP; e.ack = 1'b1; e.mis = 1'b1;
      sbq.push_back(e);
      @(posedge clk); #1;
      exp_bad = a;
    end else if (!w) begin
      e.kind = K_LOAD; e.ack = 1'b1; e.rd = 1'b1; e.daddr = ea;
      e.rdata = load_ref(sz, sx, ea);
      sbq.push_back(e);
      @(posedge clk); #1;
    end else if (sz[1]) begin
      e.kind = K_WST; e.ack = 1'b1; e.wr = 1'b1; e.daddr = ea; e.dwdata = d;
      sbq.push_back(e);
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) ref_b[i + k] = d[8*k +: 8];
    end else begin
      e.kind = K_BUSY; e.busy = 1'b1; e.rd = 1'b1; e.daddr = ea;
      sbq.push_back(e);
      @(posedge clk); #1;
      ref_b[i] = d[7:0];
      if (sz == 2'b01) ref_b[i+1] = d[15:8];
      // Held store: inputs other than req/we are scrambled, the unit must ignore them.
      addr = $urandom; wdata = $urandom; size = 2'($urandom);
      e.kind = K_BUSY; e.busy = 1'b0; e.rd = 1'b0;
      e.kind = K_RMW; e.ack = 1'b1; e.wr = 1'b1; e.daddr = ea; e.dwdata = ref_word(ea);
      e.bad = exp_bad;
      sbq.push_back(e);
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  // Monitor: compare each non-reset cycle against the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("no_rd_wr_overlap", 32'(dm_read & dm_write), 32'h0);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("ack", 32'(ack), 32'(e.ack));
          chk("busy", 32'(busy), 32'(e.busy));
          chk("misalign", 32'(misalign), 32'(e.mis));
          chk("dm_read", 32'(dm_read), 32'(e.rd));
          chk("dm_write", 32'(dm_write), 32'(e.wr));
          chk("bad_addr", bad_addr, e.bad);
          case (e.kind)
            K_LOAD: begin chk("load_dm_addr", dm_addr, e.daddr); chk("load_rdata", rdata, e.rdata); end
            K_WST:  begin chk("sw_dm_addr", dm_addr, e.daddr); chk("sw_dm_wdata", dm_wdata, e.dwdata); end
            K_BUSY: chk("rmw_rd_addr", dm_addr, e.daddr);
            K_RMW:  begin chk("rmw_wr_addr", dm_addr, e.daddr); chk("rmw_wdata", dm_wdata, e.dwdata); end
            default: chk("trap_rdata", rdata, 32'h0);
          endcase
        end else begin
          chk("idle_quiet", {27'h0, ack, busy, misalign, dm_read, dm_write}, 32'h0);
          chk("idle_rdata", rdata, 32'h0);
          chk("idle_bad_addr", bad_addr, exp_bad);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int a = 0; a < 256; a += 4) set_word(a, $urandom);
    rst = 1'b1; req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h13; wdata = 32'h55;
    #12;
    chk("reset_outputs", {27'h0, ack, busy, misalign, dm_read, dm_write}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_bad_addr", bad_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    idle_cycle();

    set_word(32'h10, 32'h8899AABB);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h55);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("sb_mem_word", mem[4], 32'h5599AABB);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    // Halfword store aborted by reset during its write cycle.
    req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hBEEF;
    e = '{kind: K_BUSY, ack: 1'b0, busy: 1'b1, mis: 1'b0, rd: 1'b1, wr: 1'b0,
          rdata: 32'h0, daddr: 32'h20, dwdata: 32'h0, bad: exp_bad};
    sbq.push_back(e);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_dm_write", 32'(dm_write), 32'h0);
    chk("abort_ack", 32'(ack), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; exp_bad = 32'h0;
    idle_cycle();
    chk("abort_mem_unchanged", mem[8], 32'h12345678);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    idle_cycle();
    issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h15, 32'hCAFE);
    issue(1'b0, 2'b11, 1'b0, 32'h14, 32'h0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      else issue(1'($urandom), 2'($urandom), 1'($urandom),
                 32'($urandom_range(0, 255)), $urandom);
    end
    idle_cycle();
    idle_cycle();
    chk("queue_drained", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end sitting directly upstream of the word-addressed data memory in the MEM stage. It accepts byte, halfword and word accesses from the pipeline and drives the memory's address, write-data, read-strobe and write-strobe. Loads complete in one cycle, with lane extraction and sign/zero extension. Sub-word stores take a two-cycle read-modify-write, and the unit stalls the pipeline for the first of those cycles.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  system clock; memory writes land on its falling edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request from the MEM stage.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- sign_ext  in  1  sign-extend sub-word loads (lb/lh) when 1, zero-extend when 0.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, extended.
- ack  out  1  access completes this cycle.
- busy  out  1  stall request to the pipeline.
- misalign  out  1  misaligned access flagged this cycle.
- bad_addr  out  32  address of the last misaligned access.
- dm_addr  out  32  byte address to memory (memory drops bits 1:0).
- dm_wdata  out  32  word to write.
- dm_read  out  1  memory read strobe.
- dm_write  out  1  memory write strobe.
- dm_rdata  in  32  memory read word; high-Z when dm_read=0 and never sampled then.

## Operation
- Lane convention: little-endian. Byte k of a word is bits [8k+7:8k], with k = addr[1:0]. Halfword h = addr[1] is bits [16h+15:16h].
- FSM states:
  - IDLE: the only state that accepts requests.
  - RMW_WR: entered only from a sub-word store.
- IDLE, req=0: all dm_* outputs 0, rdata 0, ack 0, busy 0.
- IDLE, load:
  - dm_read=1, dm_addr=addr.
  - rdata is the selected lane of dm_rdata, extended per sign_ext; a word load passes through unchanged.
  - ack=1. Stay in IDLE.
- IDLE, word store: dm_write=1, dm_addr=addr, dm_wdata=wdata, ack=1. Stay in IDLE.
- IDLE, byte/half store:
  - dm_read=1, busy=1, ack=0.
  - At the rising edge, latch addr into addr_q.
  - Also latch merge_q = dm_rdata with the target lane replaced by wdata[7:0] or wdata[15:0].
  - Go to RMW_WR.
- RMW_WR:
  - dm_write=1, dm_addr=addr_q, dm_wdata=merge_q, ack=1, busy=0; the write lands at the falling edge.
  - req/we/size/addr are ignored; the pipeline is still presenting the held store.
  - Return to IDLE at the next rising edge.
- The unit never issues dm_read and dm_write in the same cycle.

## Timing
- Load and word-store latency: 0 cycles; ack in the request cycle.
- Sub-word store: 2 cycles. busy is high in cycle 1 only; ack is in cycle 2.
- Back-to-back requests are accepted every cycle while in IDLE.
- Reset values: state IDLE, addr_q 0, merge_q 0, bad_addr 0. All outputs are 0 while rst is high.
- Reset asserted in RMW_WR: dm_write drops immediately, the write is abandoned, and memory is unchanged.

## Configuration
- Macro: MISALIGN_TRAP_EN. A halfword access is misaligned when addr[0]=1; a word access is misaligned when addr[1:0]≠0.
- Defined:
  - On a misaligned request in IDLE: misalign=1 and ack=1 that cycle.
  - No dm_read/dm_write and no state change; rdata=0.
  - bad_addr <= addr at the rising edge.
- Undefined:
  - Misaligned addresses are silently aligned down: halfword clears bit 0, word clears bits 1:0.
  - misalign and bad_addr are tied 0.

## Test plan
- Memory word 0x10 = 0x8899AABB; lb addr 0x11, sign_ext=1 -> rdata 0xFFFFFFAA, ack in the same cycle. lbu addr 0x11 (sign_ext=0) -> 0x000000AA.
- lh addr 0x12, sign_ext=1 -> 0xFFFF8899. lhu addr 0x12 -> 0x00008899. lw 0x10 -> 0x8899AABB.
- sb addr 0x13, wdata 0x55 -> busy=1 in cycle 1, dm_write with 0x5599AABB in cycle 2, ack in cycle 2. A following lw 0x10 returns 0x5599AABB.
- sw 0x20 0x12345678 then lw 0x20 on consecutive cycles -> no busy; 0x12345678 is read.
- sh addr 0x20, wdata 0xBEEF, with rst pulsed in RMW_WR -> dm_write drops at once and the word stays 0x12345678.
- Misaligned access, lw 0x22:
  - With MISALIGN_TRAP_EN: misalign=1, no memory strobe, bad_addr=0x00000022 next cycle.
  - Without it: reads the word at 0x20.
